// File: rtl/clock_reset_ctrl.sv
// ============================================================================
// Module  : clock_reset_ctrl
// Brief   : Derives core/memory clocks from one system clock and sequences
//           core reset release, run counting and halt/timeout completion.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_reset_ctrl #(
  parameter int DIV         = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int RUN_LIMIT   = 1300
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  output logic        imem_clock,
  output logic        dmem_clock,
  output logic        processor_clock,
  output logic        regfile_clock,
  output logic        core_reset,
  output logic [31:0] run_count,
  output logic        done,
  output logic        timeout
);

  localparam int c_div_w  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int c_hold_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(DIV - 1);
  localparam logic [c_div_w-1:0]  c_div_half  = c_div_w'(DIV / 2);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [31:0]         c_run_limit = 32'(RUN_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_sync;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_div_w-1:0]  r_div_cnt;

  logic w_active;
  logic w_pclk_next;
  logic w_limit_hit;
  logic w_count_en;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_SYNC;
      // Leave SYNC once the release edge has crossed both synchronizer flops.
      S_SYNC:  if (r_sync[1]) w_state_next = S_HOLD;
      S_HOLD:  if (r_hold_cnt == c_hold_last) w_state_next = S_RUN;
      S_RUN:   if (halt || w_limit_hit) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Clock outputs are registered from the next state so IDLE/DONE show 0 at once.
  assign w_active    = (w_state_next == S_SYNC) || (w_state_next == S_HOLD) ||
                       (w_state_next == S_RUN);
  assign w_pclk_next = w_active && (r_div_cnt < c_div_half);
  assign w_limit_hit = (run_count >= c_run_limit);
  assign w_count_en  = (r_state == S_RUN) && (w_state_next == S_RUN) &&
                       w_pclk_next && !processor_clock;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_sync          <= 2'b00;
      r_hold_cnt      <= '0;
      r_div_cnt       <= '0;
      imem_clock      <= 1'b0;
      dmem_clock      <= 1'b0;
      processor_clock <= 1'b0;
      regfile_clock   <= 1'b0;
      core_reset      <= 1'b1;
      run_count       <= '0;
      done            <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_sync          <= {r_sync[0], 1'b1};
      r_hold_cnt      <= (r_state == S_HOLD) ? r_hold_cnt + 1'b1 : '0;
      if (!w_active)
        r_div_cnt <= '0;
      else if (r_div_cnt == c_div_last)
        r_div_cnt <= '0;
      else
        r_div_cnt <= r_div_cnt + 1'b1;
      processor_clock <= w_pclk_next;
      regfile_clock   <= w_pclk_next;
      imem_clock      <= w_active & ~imem_clock;
      dmem_clock      <= w_active & imem_clock;
      core_reset      <= !((w_state_next == S_RUN) || (w_state_next == S_DONE));
      if (w_count_en && (run_count != 32'hFFFF_FFFF))
        run_count <= run_count + 32'd1;
      // Halt wins over the limit when both occur in the same cycle.
      if ((r_state == S_RUN) && (w_state_next == S_DONE)) begin
        done    <= 1'b1;
        timeout <= ~halt;
      end
    end
  end

endmodule

`default_nettype wire
